// File: rtl/button_conditioner_if.sv
// Bundle of raw button inputs and conditioned outputs for button_conditioner.
interface button_conditioner_if;
    logic btn_inc_raw;
    logic btn_dec_raw;
    logic increment;
    logic decrease;
    logic inc_held;
    logic dec_held;

    modport master (
        output btn_inc_raw,
        output btn_dec_raw,
        input  increment,
        input  decrease,
        input  inc_held,
        input  dec_held
    );

    modport slave (
        input  btn_inc_raw,
        input  btn_dec_raw,
        output increment,
        output decrease,
        output inc_held,
        output dec_held
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-channel button conditioner: synchronize, debounce, auto-repeat and
// arbitrate increment/decrease pulses so that they are never both asserted.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          REPEAT_ENABLE   = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave bus
);

    localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY;
    localparam int unsigned MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int unsigned CNT_W = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [1:0]       RAW_RELEASED = {2{ACTIVE_LOW}};

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StHeld,
        StRepeat,
        StReleaseWait
    } state_e;

    // Channel index 0 is increment, 1 is decrease.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       pressed;
    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       cand;
    logic [1:0]       held_d, held_q;
    logic             inc_q, dec_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RAW_RELEASED;
            sync2_q <= RAW_RELEASED;
        end else begin
            sync1_q <= {bus.btn_dec_raw, bus.btn_inc_raw};
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            cand[ch]    = 1'b0;
            case (state_q[ch])
                StIdle: begin
                    if (pressed[ch]) begin
                        state_d[ch] = StPressWait;
                        cnt_d[ch]   = '0;
                    end
                end
                StPressWait: begin
                    if (!pressed[ch]) begin
                        state_d[ch] = StIdle;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == DEB_LAST) begin
                        state_d[ch] = StHeld;
                        cnt_d[ch]   = '0;
                        cand[ch]    = 1'b1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                StHeld: begin
                    if (!pressed[ch]) begin
                        state_d[ch] = StReleaseWait;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == DELAY_LAST) begin
                        // Without repeat the counter parks here until release.
                        if (REPEAT_ENABLE) begin
                            state_d[ch] = StRepeat;
                            cnt_d[ch]   = '0;
                            cand[ch]    = 1'b1;
                        end
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!pressed[ch]) begin
                        state_d[ch] = StReleaseWait;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == PERIOD_LAST) begin
                        cnt_d[ch] = '0;
                        cand[ch]  = 1'b1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                StReleaseWait: begin
                    if (pressed[ch]) begin
                        state_d[ch] = StHeld;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == DEB_LAST) begin
                        state_d[ch] = StIdle;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                default: begin
                    state_d[ch] = StIdle;
                    cnt_d[ch]   = '0;
                end
            endcase
            held_d[ch] = (state_d[ch] == StHeld) || (state_d[ch] == StRepeat) ||
                         (state_d[ch] == StReleaseWait);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= StIdle;
                cnt_q[ch]   <= '0;
            end
            held_q <= 2'b00;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            held_q <= held_d;
            // Coincident candidates cancel; neither is carried over.
            inc_q  <= cand[0] & ~cand[1];
            dec_q  <= cand[1] & ~cand[0];
        end
    end

    assign bus.increment = inc_q;
    assign bus.decrease  = dec_q;
    assign bus.inc_held  = held_q[0];
    assign bus.dec_held  = held_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one active-high DUT with repeat, one
// active-low DUT with repeat disabled; edge numbers count from the first press.
module tb_button_conditioner;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    button_conditioner_if bus_a ();
    button_conditioner_if bus_b ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_ENABLE   (1'b1),
        .ACTIVE_LOW      (1'b0)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_ENABLE   (1'b0),
        .ACTIVE_LOW      (1'b1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset deasserted just after an edge; the next edge is edge 1.
    task automatic do_reset();
        bus_a.btn_inc_raw = 1'b0;
        bus_a.btn_dec_raw = 1'b0;
        bus_b.btn_inc_raw = 1'b1;
        bus_b.btn_dec_raw = 1'b1;
        reset = 1'b1;
        step();
        step();
        check("rst_a_inc",  bus_a.increment, 0);
        check("rst_a_dec",  bus_a.decrease,  0);
        check("rst_a_ih",   bus_a.inc_held,  0);
        check("rst_a_dh",   bus_a.dec_held,  0);
        check("rst_b_inc",  bus_b.increment, 0);
        check("rst_b_dec",  bus_b.decrease,  0);
        check("rst_b_ih",   bus_b.inc_held,  0);
        check("rst_b_dh",   bus_b.dec_held,  0);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_a.btn_inc_raw = 1'b0;
        bus_a.btn_dec_raw = 1'b0;
        bus_b.btn_inc_raw = 1'b1;
        bus_b.btn_dec_raw = 1'b1;

        // Clean press.
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            bus_a.btn_inc_raw = 1'b1;
            step();
            check($sformatf("clean_inc@%0d", e), bus_a.increment, (e == 7));
            check($sformatf("clean_dec@%0d", e), bus_a.decrease, 0);
            check($sformatf("clean_held@%0d", e), bus_a.inc_held, (e >= 7));
        end

        // Bounce 1,0,1,0,1 then steady.
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            bus_a.btn_inc_raw = (e == 2 || e == 4) ? 1'b0 : 1'b1;
            step();
            check($sformatf("bounce_inc@%0d", e), bus_a.increment, (e == 11));
        end

        // Auto-repeat, then release.
        do_reset();
        for (int e = 1; e <= 70; e++) begin
            bus_a.btn_inc_raw = (e <= 60);
            step();
            check($sformatf("rep_inc@%0d", e), bus_a.increment,
                  (e == 7 || e == 27 || e == 35 || e == 43 || e == 51 || e == 59));
            check($sformatf("rep_dec@%0d", e), bus_a.decrease, 0);
            if (e <= 62) check($sformatf("rep_held@%0d", e), bus_a.inc_held, (e >= 7));
            else if (e >= 68) check($sformatf("rep_held@%0d", e), bus_a.inc_held, 0);
        end

        // Simultaneous presses cancel.
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            bus_a.btn_inc_raw = 1'b1;
            bus_a.btn_dec_raw = 1'b1;
            step();
            check($sformatf("sim_inc@%0d", e), bus_a.increment, 0);
            check($sformatf("sim_dec@%0d", e), bus_a.decrease, 0);
            check($sformatf("sim_ih@%0d", e), bus_a.inc_held, (e >= 7));
            check($sformatf("sim_dh@%0d", e), bus_a.dec_held, (e >= 7));
        end

        // Reset mid-debounce restarts from IDLE.
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            bus_a.btn_dec_raw = 1'b1;
            reset = (e == 5);
            step();
            check($sformatf("mid_dec@%0d", e), bus_a.decrease, (e == 12));
            check($sformatf("mid_inc@%0d", e), bus_a.increment, 0);
            check($sformatf("mid_dh@%0d", e), bus_a.dec_held, (e >= 12));
        end
        reset = 1'b0;

        // Active-low input, repeat disabled.
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            bus_b.btn_dec_raw = 1'b0;
            step();
            check($sformatf("al_dec@%0d", e), bus_b.decrease, (e == 7));
            check($sformatf("al_inc@%0d", e), bus_b.increment, 0);
            check($sformatf("al_dh@%0d", e), bus_b.dec_held, (e >= 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
